// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Brief    : Round-robin burst arbiter sharing one FIFO write port among
//            N_REQ producers, with FIFO-full backpressure.
//            Optional source-ID tagging on the write word: FIFO_ARB_TAG_EN.
// Revision : 1.0  initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int N_REQ      = 4,
    parameter int WORD_WIDTH = 8,
    parameter int BURST      = 4,
    localparam int IDW       = (N_REQ > 1) ? $clog2(N_REQ) : 1,
`ifdef FIFO_ARB_TAG_EN
    localparam int OW        = WORD_WIDTH + IDW
`else
    localparam int OW        = WORD_WIDTH
`endif
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_REQ-1:0]              i_req,
    input  logic [N_REQ*WORD_WIDTH-1:0]   i_data,
    input  logic                          i_full,
    output logic [N_REQ-1:0]              o_ack,
    output logic                          o_w_en,
    output logic [OW-1:0]                 o_w_data,
    output logic [N_REQ-1:0]              o_grant,
    output logic                          o_busy
);

    localparam int CW = $clog2(BURST + 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [IDW-1:0]         r_gid;
    logic [IDW-1:0]         w_gid_nxt;
    logic [IDW-1:0]         r_last;
    logic [IDW-1:0]         w_last_nxt;
    logic [CW-1:0]          r_cnt;
    logic [CW-1:0]          w_cnt_nxt;

    logic [WORD_WIDTH-1:0]  w_words [N_REQ];
    logic                   w_xfer;
    logic                   w_last_word;
    logic [N_REQ-1:0]       w_gid_onehot;
    logic [N_REQ-1:0]       w_ack;
    logic                   w_w_en;
    logic [OW-1:0]          w_w_data;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign w_words[g] = i_data[g*WORD_WIDTH +: WORD_WIDTH];
    end

    // Rotating-priority search starting just after the previous owner.
    function automatic logic [IDW-1:0] f_pick(
        input logic [N_REQ-1:0] req,
        input logic [IDW-1:0]   last
    );
        logic [IDW-1:0] pick;
        logic [IDW-1:0] idx;
        logic           found;
        pick  = '0;
        found = 1'b0;
        for (int d = 1; d <= N_REQ; d++) begin
            idx = IDW'((int'(last) + d) % N_REQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
        return pick;
    endfunction

    function automatic logic [N_REQ-1:0] f_onehot(input logic [IDW-1:0] id);
        logic [N_REQ-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    assign w_gid_onehot = f_onehot(r_gid);
    assign w_last_word  = (r_cnt == CW'(BURST - 1));
    // Reset gates the write in the same cycle so an aborted burst never leaks a word.
    assign w_xfer       = (r_state == S_BURST) && i_req[r_gid] && !i_full && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_gid   <= '0;
            r_last  <= IDW'(N_REQ - 1);
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gid   <= w_gid_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gid_nxt   = r_gid;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        w_ack       = '0;
        w_w_en      = 1'b0;
        w_w_data    = '0;

        if (w_xfer) begin
            w_ack    = w_gid_onehot;
            w_w_en   = 1'b1;
`ifdef FIFO_ARB_TAG_EN
            w_w_data = {r_gid, w_words[r_gid]};
`else
            w_w_data = w_words[r_gid];
`endif
        end

        case (r_state)
            S_IDLE: begin
                if (|i_req) begin
                    w_gid_nxt   = f_pick(i_req, r_last);
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_BURST;
                end
            end
            S_BURST: begin
                if (w_xfer) begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
                // A dropped request ends the grant early; full alone never does.
                if ((w_xfer && w_last_word) || !i_req[r_gid]) begin
                    w_state_nxt = S_IDLE;
                    w_last_nxt  = r_gid;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign o_ack    = w_ack;
    assign o_w_en   = w_w_en;
    assign o_w_data = w_w_data;
    assign o_busy   = (r_state == S_BURST);
    assign o_grant  = (r_state == S_BURST) ? w_gid_onehot : '0;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Brief    : Scoreboard bench for fifo_wr_arbiter with producer queues and a
//            behavioural owner/turn model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    localparam int N_REQ = 4;
    localparam int W     = 8;
    localparam int BURST = 4;
    localparam int IDW   = 2;
    localparam int DW    = N_REQ * W;
`ifdef FIFO_ARB_TAG_EN
    localparam int OW    = W + IDW;
`else
    localparam int OW    = W;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [N_REQ-1:0]  i_req;
    logic [DW-1:0]     i_data;
    logic              i_full;
    logic [N_REQ-1:0]  o_ack;
    logic              o_w_en;
    logic [OW-1:0]     o_w_data;
    logic [N_REQ-1:0]  o_grant;
    logic              o_busy;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .N_REQ      (N_REQ),
        .WORD_WIDTH (W),
        .BURST      (BURST)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .i_req    (i_req),
        .i_data   (i_data),
        .i_full   (i_full),
        .o_ack    (o_ack),
        .o_w_en   (o_w_en),
        .o_w_data (o_w_data),
        .o_grant  (o_grant),
        .o_busy   (o_busy)
    );

    typedef struct {
        string            ph;
        logic [N_REQ-1:0] ack;
        logic             wen;
        logic [OW-1:0]    data;
        logic [N_REQ-1:0] grant;
        logic             busy;
    } exp_t;

    // kind 0: open write-count window, 1: check window count, 2: timeout
    typedef struct {
        int    kind;
        string name;
        int    n;
    } mark_t;

    exp_t          exp_q[$];
    mark_t         mark_q[$];
    logic [W-1:0]  src_q[N_REQ][$];

    int m_owner;
    int m_last;
    int m_n;
    int m_acks;

    int tests_run    = 0;
    int tests_failed = 0;
    int wr_since     = 0;
    exp_t  mon_e;
    mark_t mon_m;

    always @(negedge clk) begin
        while (mark_q.size() > 0) begin
            mon_m = mark_q.pop_front();
            if (mon_m.kind == 0) begin
                wr_since = 0;
            end else if (mon_m.kind == 1) begin
                tests_run++;
                if (wr_since != mon_m.n) begin
                    tests_failed++;
                    $display("FAIL %s: writes got %0d expected %0d", mon_m.name, wr_since, mon_m.n);
                end
            end else begin
                tests_run++;
                tests_failed++;
                $display("FAIL %s: cycle budget expired got pending expected drained", mon_m.name);
            end
        end
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            tests_run++;
            if (o_ack !== mon_e.ack || o_w_en !== mon_e.wen || o_w_data !== mon_e.data ||
                o_grant !== mon_e.grant || o_busy !== mon_e.busy) begin
                tests_failed++;
                $display("FAIL %s: got ack=%b wen=%b data=%h grant=%b busy=%b expected ack=%b wen=%b data=%h grant=%b busy=%b",
                         mon_e.ph, o_ack, o_w_en, o_w_data, o_grant, o_busy,
                         mon_e.ack, mon_e.wen, mon_e.data, mon_e.grant, mon_e.busy);
            end
        end else if (o_w_en !== 1'b0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL unexpected_write: got w_en=%b expected 0", o_w_en);
        end
        if (o_w_en === 1'b1) wr_since++;
    end

    task automatic mark(input int kind, input string name, input int n);
        mark_t m;
        m.kind = kind;
        m.name = name;
        m.n    = n;
        mark_q.push_back(m);
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = N_REQ - 1;
        m_n     = 0;
    endtask

    function automatic bit pending();
        bit p = (m_owner >= 0);
        for (int k = 0; k < N_REQ; k++) if (src_q[k].size() > 0) p = 1'b1;
        return p;
    endfunction

    // One clock: drive inputs, push expected outputs, advance the model.
    task automatic step(input bit full, input bit rst, input string ph);
        logic [N_REQ-1:0] req;
        logic [DW-1:0]    dat;
        logic [W-1:0]     word;
        exp_t             e;
        int               own;
        bit               xfer;
        bit               found;
        int               c;
        req = '0;
        dat = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (src_q[k].size() > 0) begin
                req = req | (N_REQ'(1) << k);
                dat = dat | (DW'(src_q[k][0]) << (k * W));
            end
        end
        i_req  = req;
        i_data = dat;
        i_full = full;
        reset  = rst;

        own  = m_owner;
        xfer = (own >= 0) && (((req >> own) & 1) != 0) && !full && !rst;
        word = xfer ? src_q[own][0] : '0;
        e.ph    = ph;
        e.busy  = (own >= 0);
        e.grant = (own >= 0) ? (N_REQ'(1) << own) : '0;
        e.wen   = xfer;
        e.ack   = xfer ? e.grant : '0;
`ifdef FIFO_ARB_TAG_EN
        e.data  = xfer ? {IDW'(own), word} : '0;
`else
        e.data  = word;
`endif
        exp_q.push_back(e);

        if (rst) begin
            model_reset();
        end else if (own < 0) begin
            found = 1'b0;
            for (int d = 1; d <= N_REQ; d++) begin
                c = (m_last + d) % N_REQ;
                if (!found && ((req >> c) & 1) != 0) begin
                    found   = 1'b1;
                    m_owner = c;
                    m_n     = 0;
                end
            end
        end else begin
            if (xfer) m_n++;
            if ((xfer && m_n == BURST) || ((req >> own) & 1) == 0) begin
                m_last  = own;
                m_owner = -1;
            end
        end
        if (xfer) begin
            void'(src_q[own].pop_front());
            m_acks++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string ph, input int max);
        int c = 0;
        while (pending() && c < max) begin
            step(1'b0, 1'b0, ph);
            c++;
        end
        if (pending()) mark(2, ph, 0);
    endtask

    task automatic run_acks(input int n, input string ph, input int max);
        int target = m_acks + n;
        int c = 0;
        while (m_acks < target && c < max) begin
            step(1'b0, 1'b0, ph);
            c++;
        end
        if (m_acks < target) mark(2, ph, 0);
    endtask

    initial begin
        reset  = 1'b1;
        i_req  = '0;
        i_data = '0;
        i_full = 1'b0;
        m_acks = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;

        repeat (2) step(1'b0, 1'b1, "reset_state");
        repeat (5) step(1'b0, 1'b0, "idle_no_req");

        mark(0, "rr", 0);
        for (int k = 0; k < 12; k++) begin
            src_q[0].push_back(8'h10 + 8'(k));
            src_q[2].push_back(8'h20 + 8'(k));
        end
        drain("rr_0_2", 200);
        mark(1, "rr_writes", 24);

        mark(0, "drop", 0);
        src_q[1].push_back(8'h31);
        src_q[1].push_back(8'h32);
        drain("drop_after_2", 50);
        mark(1, "drop_writes", 2);

        mark(0, "rotate", 0);
        src_q[0].push_back(8'h40);
        src_q[2].push_back(8'h42);
        drain("rotate_from_2", 50);
        mark(1, "rotate_writes", 2);

        mark(0, "full", 0);
        for (int k = 0; k < 4; k++) src_q[3].push_back(8'h50 + 8'(k));
        run_acks(2, "full_pre", 20);
        repeat (3) step(1'b1, 1'b0, "full_hold");
        drain("full_post", 50);
        mark(1, "full_writes", 4);

        mark(0, "rst_mid", 0);
        for (int k = 0; k < 4; k++) src_q[1].push_back(8'h60 + 8'(k));
        run_acks(2, "rst_pre", 20);
        step(1'b0, 1'b1, "rst_word3");
        src_q[0].push_back(8'h70);
        drain("rst_after", 50);
        mark(1, "rst_writes", 5);

        mark(0, "tag", 0);
        src_q[3].push_back(8'hA5);
        drain("tag_req3_a5", 20);
        mark(1, "tag_writes", 1);

        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (src_q[k].size() == 0 && $urandom_range(0, 7) == 0) begin
                    for (int j = 0; j < int'($urandom_range(1, 6)); j++)
                        src_q[k].push_back(8'($urandom));
                end
            end
            step($urandom_range(0, 3) == 0, $urandom_range(0, 149) == 0, "random");
        end
        drain("random_drain", 500);

        repeat (2) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
